// File: rtl/pipe_stage_pkg.sv
// Shared types and constants for the pipeline stage register.
//   ps_state_t : occupancy of the stage (main entry / skid entry)
//   RV32_NOP   : default bubble payload (addi x0,x0,0)
package pipe_stage_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_HALF  = 2'd1,
      PS_FULL  = 2'd2
   } ps_state_t;

   localparam logic [31:0] RV32_NOP = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and holds at all-ones.
//   clk   : clock
//   rst   : asynchronous active-low reset, clears count
//   inc   : count enable for this cycle
//   count : current count (registered)
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Full throughput, in_ready is a register output (no comb path from out_ready),
// synchronous flush to the RESET_VAL bubble.
//   clk, rst            : clock, asynchronous active-low reset
//   flush               : synchronous squash of all held entries
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload (registered)
//   stall_cnt/bubble_cnt: saturating perf counters, present only when
//                         PIPE_STAGE_REG_PERF_EN is defined
module pipe_stage_reg
   import pipe_stage_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RV32_NOP),
   parameter int unsigned      CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_REG_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
`endif
);

   ps_state_t        state_q, state_nxt;
   logic [WIDTH-1:0] main_q, main_nxt;
   logic [WIDTH-1:0] skid_q, skid_nxt;
   logic             out_valid_q;
   logic             in_ready_q;
   logic             in_xfer;
   logic             out_xfer;

   assign in_xfer  = in_valid && in_ready_q;
   assign out_xfer = out_valid_q && out_ready;

   // Next-state and data steering
   always_comb begin
      state_nxt = state_q;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      unique case (state_q)
         PS_EMPTY: begin
            if (in_xfer) begin
               state_nxt = PS_HALF;
               main_nxt  = in_data;
            end
         end
         PS_HALF: begin
            if (in_xfer && out_xfer) begin
               main_nxt = in_data;
            end else if (in_xfer) begin
               state_nxt = PS_FULL;
               skid_nxt  = in_data;
            end else if (out_xfer) begin
               // main keeps its value so out_data holds while out_valid=0
               state_nxt = PS_EMPTY;
            end
         end
         PS_FULL: begin
            if (out_xfer) begin
               state_nxt = PS_HALF;
               main_nxt  = skid_q;
            end
         end
         default: begin
            state_nxt = PS_EMPTY;
            main_nxt  = RESET_VAL;
         end
      endcase
      // Flush discards everything, including a same-cycle incoming item
      if (flush) begin
         state_nxt = PS_EMPTY;
         main_nxt  = RESET_VAL;
      end
   end

   // State and payload registers; handshake outputs registered from next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= PS_EMPTY;
         main_q      <= RESET_VAL;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_nxt;
         main_q      <= main_nxt;
         skid_q      <= skid_nxt;
         out_valid_q <= (state_nxt != PS_EMPTY);
         in_ready_q  <= (state_nxt != PS_FULL);
      end
   end

   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;
   assign out_data  = main_q;

`ifdef PIPE_STAGE_REG_PERF_EN
   // Perf counters: cleared only by rst, unaffected by flush
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (out_valid_q && !out_ready),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (!out_valid_q),
      .count (bubble_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks for pipe_stage_reg.
// Perf counter checks are included when PIPE_STAGE_REG_PERF_EN is defined.
module tb_pipe_stage_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
`ifdef PIPE_STAGE_REG_PERF_EN
   logic [3:0]  stall_cnt;
   logic [3:0]  bubble_cnt;
`endif

   int vectors;
   int miscompares;
   logic [31:0] q[$];

   pipe_stage_reg #(.WIDTH(32), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef PIPE_STAGE_REG_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .bubble_cnt(bubble_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock edge, then return at the following falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      in_data     = 32'h0;
      out_ready   = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data",  out_data, NOP);
      check("rst_ready", 32'(in_ready), 32'd1);
      rst = 1'b1;

`ifdef PIPE_STAGE_REG_PERF_EN
      tick();
      check("bubble_first", 32'(bubble_cnt), 32'd1);
`endif

      // Back-to-back with out_ready=1
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h1234_5678;
      tick();
      check("b2b_v0", 32'(out_valid), 32'd1);
      check("b2b_d0", out_data, 32'h1234_5678);
      check("b2b_r0", 32'(in_ready), 32'd1);
      in_data = 32'h8765_4321;
      tick();
      check("b2b_v1", 32'(out_valid), 32'd1);
      check("b2b_d1", out_data, 32'h8765_4321);
      check("b2b_r1", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      tick();
      check("b2b_empty", 32'(out_valid), 32'd0);
      check("b2b_hold",  out_data, 32'h8765_4321);

      // Fill to FULL, third item held upstream, then drain in order
      out_ready = 1'b0;
      push(32'hAABB_CCDD);
      push(32'h1122_3344);
      check("full_ready", 32'(in_ready), 32'd0);
      check("full_data",  out_data, 32'hAABB_CCDD);
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      tick();
      check("full_hold_ready", 32'(in_ready), 32'd0);
      check("full_hold_data",  out_data, 32'hAABB_CCDD);
      out_ready = 1'b1;
      tick();
      check("drain_d1",    out_data, 32'h1122_3344);
      check("drain_ready", 32'(in_ready), 32'd1);
      tick();
      check("drain_d2", out_data, 32'hDEAD_BEEF);
      check("drain_v2", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      tick();
      check("drain_empty", 32'(out_valid), 32'd0);

      // Flush while FULL with a simultaneous input
      out_ready = 1'b0;
      push(32'h0101_0101);
      push(32'h0202_0202);
      in_valid = 1'b1;
      in_data  = 32'hCAFE_F00D;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_data",  out_data, NOP);
      check("flush_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      tick();
      tick();
      check("flush_stays_empty", 32'(out_valid), 32'd0);

      // Flush alongside an out-transfer in HALF
      out_ready = 1'b0;
      push(32'h0303_0303);
      out_ready = 1'b1;
      flush     = 1'b1;
      tick();
      flush     = 1'b0;
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_out_data",  out_data, NOP);

      // Asynchronous reset mid-stream while FULL
      out_ready = 1'b0;
      push(32'h0404_0404);
      push(32'h0505_0505);
      check("pre_rst_ready", 32'(in_ready), 32'd0);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_data",  out_data, NOP);
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;

`ifdef PIPE_STAGE_REG_PERF_EN
      // Perf counters with CNT_W=4 saturate at 15
      repeat (20) tick();
      check("bubble_sat", 32'(bubble_cnt), 32'd15);
      push(32'h0606_0606);
      check("stall_0", 32'(stall_cnt), 32'd0);
      tick();
      check("stall_1", 32'(stall_cnt), 32'd1);
      repeat (19) tick();
      check("stall_sat", 32'(stall_cnt), 32'd15);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("stall_after_flush",  32'(stall_cnt), 32'd15);
      check("bubble_after_flush", 32'(bubble_cnt), 32'd15);
`else
      flush = 1'b1;
      tick();
      flush = 1'b0;
`endif

      // Random valid/ready against a FIFO scoreboard, starting EMPTY
      q.delete();
      repeat (3000) begin
         check("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
         check("rnd_ready", 32'(in_ready),  32'(q.size() < 2));
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_data   = $urandom;
         if (out_valid && out_ready && (q.size() != 0)) begin
            check("rnd_data", out_data, q[0]);
            void'(q.pop_front());
         end
         if (in_valid && in_ready) q.push_back(in_data);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
